cpu_regfile: RTL
================

// Module: cpu_regfile
// PURPOSE
//   Register file and instruction-pointer owner for the core. It serves register
//   reads from ISA executors (reg_id/reg_re -> reg_out) and register writes, and
//   it holds the IP, which executors redirect with ip_set/ip_val.
//   One instance sits in the core. It sits between the executor mux and fetch.
// PARAMETERS
//   XLEN      64  register and IP width in bits
//   NREGS     16  number of architectural registers (1..16, index width fixed at 4)
//   IP_RESET  0   IP value loaded on reset
// PORTS
//   clk          in   1     clock, all state updates on posedge
//   rst          in   1     synchronous reset, active-high
//   reg_id       in   4     read register index
//   reg_re       in   1     read enable
//   reg_out      out  XLEN  read data
//   reg_we       in   1     write enable
//   reg_wid      in   4     write register index
//   reg_in       in   XLEN  write data
//   ip_set       in   1     load IP from ip_val
//   ip_val       in   XLEN  new IP value
//   ip_inc       in   1     advance IP by ip_step
//   ip_step      in   4     byte increment for ip_inc (0..15)
//   ip           out  XLEN  current IP, registered
//   ip_redirect  out  1     one-cycle pulse on the cycle after an ip_set load
// BEHAVIOUR
//   Reset (rst=1 at posedge): all regs = 0, ip = IP_RESET, read-hold = 0, ip_redirect = 0.
//     Reset takes priority over every request in the same cycle.
//     A read/write/ip request in flight during reset is dropped; no retry.
//   Read: reg_out = regs[reg_id] combinationally while reg_re=1, so data is
//     valid in the same cycle reg_re is high. An executor that raises reg_re at
//     edge N and samples at edge N+1 gets the value.
//     At every posedge with reg_re=1 the read-hold register captures that value.
//     While reg_re=0, reg_out = read-hold and is stable.
//   Write: at posedge with reg_we=1 and reg_wid<NREGS, regs[reg_wid] <= reg_in.
//     reg_wid>=NREGS: the write is ignored. reg_id>=NREGS: the read returns 0.
//   Read/write same index, same cycle: see REGFILE_BYPASS_EN.
//     The read-hold captures the same value that reg_out shows that cycle.
//   IP update at posedge, in priority order:
//     ip_set -> ip <= ip_val; else ip_inc -> ip <= ip + ip_step (mod 2^XLEN,
//     wraps silently); else hold. ip_set together with ip_inc: set wins and
//     the increment is discarded.
//   ip_redirect <= ip_set (registered). It is 1 for exactly the cycle after each
//     posedge where ip_set was sampled high. Back-to-back ip_set gives a
//     continuous high, and ip follows the last ip_val.
//   Latency: read 0 cycles; write visible to reads from the next cycle;
//     ip visible 1 cycle after set/inc.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: if reg_re && reg_we && reg_id==reg_wid (<NREGS)
//     in the same cycle, reg_out = reg_in (write-to-read forwarding).
//   Not defined: reg_out returns the pre-write value in that cycle. The new value
//     is seen from the next cycle.
// TESTING
//   1 rst high 2 cycles, IP_RESET=0x100 -> ip=0x100, reg_out=0, ip_redirect=0, all regs read 0.
//   2 we r3=0xDEAD_BEEF; next cycle re r3 -> reg_out=0xDEADBEEF same cycle;
//     drop re -> reg_out holds 0xDEADBEEF.
//   3 same cycle we r5=0x55 and re r5 (r5 was 0x11) -> reg_out=0x55 with
//     REGFILE_BYPASS_EN, 0x11 without; next-cycle read = 0x55 in both builds.
//   4 ip=0xFFFF_FFFF_FFFF_FFFC, ip_inc with step 8 -> ip=0x4 (wrap-around);
//     ip_inc with step 0 -> ip unchanged.
//   5 ip_set=1 (ip_val=0x2000) + ip_inc=1 (step 4) same cycle -> ip=0x2000,
//     ip_redirect=1 for exactly one cycle.
//   6 rst asserted with we r1=7 and ip_set pending -> r1=0, ip=IP_RESET,
//     no ip_redirect; we to reg_wid=15 with NREGS=8 -> no register changes.

Source files
------------

// File: rtl/cpu_regfile.sv
// Register file and IP owner: reads are combinational with a hold register, writes and IP updates land on posedge.
// Read latency 0 cycles, write/IP latency 1 cycle; no backpressure, every request is accepted or dropped by rule.
// Optional write-to-read forwarding is built in when REGFILE_BYPASS_EN is defined.
module cpu_regfile #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 16,
    parameter logic [XLEN-1:0] IP_RESET = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [3:0]      i_reg_id,
    input  logic            i_reg_re,
    output logic [XLEN-1:0] o_reg_out,
    input  logic            i_reg_we,
    input  logic [3:0]      i_reg_wid,
    input  logic [XLEN-1:0] i_reg_in,
    input  logic            i_ip_set,
    input  logic [XLEN-1:0] i_ip_val,
    input  logic            i_ip_inc,
    input  logic [3:0]      i_ip_step,
    output logic [XLEN-1:0] o_ip,
    output logic            o_ip_redirect
);

    localparam logic [4:0] LP_NREGS = 5'(NREGS);

    logic [XLEN-1:0] w_regs [16];
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic            w_fwd;
    logic [XLEN-1:0] w_rd_arr;
    logic [XLEN-1:0] w_rd_val;

    logic [XLEN-1:0] r_hold;
    logic [XLEN-1:0] r_ip;
    logic            r_ip_redirect;

    assign w_wr_ok = i_reg_we && ({1'b0, i_reg_wid} < LP_NREGS);
    assign w_rd_ok = ({1'b0, i_reg_id} < LP_NREGS);

    // Entries at or above NREGS are not built; they read as constant zero.
    for (genvar g = 0; g < 16; g++) begin : g_ent
        if (g < NREGS) begin : g_live
            logic [XLEN-1:0] r_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_q <= '0;
                end else if (w_wr_ok && (i_reg_wid == 4'(g))) begin
                    r_q <= i_reg_in;
                end
            end
            assign w_regs[g] = r_q;
        end else begin : g_none
            assign w_regs[g] = '0;
        end
    end

    assign w_rd_arr = w_rd_ok ? w_regs[i_reg_id] : '0;

`ifdef REGFILE_BYPASS_EN
    assign w_fwd = i_reg_re && w_wr_ok && (i_reg_id == i_reg_wid);
`else
    assign w_fwd = 1'b0;
`endif

    assign w_rd_val  = w_fwd ? i_reg_in : w_rd_arr;
    assign o_reg_out = i_reg_re ? w_rd_val : r_hold;

    // The hold captures exactly what reg_out showed, forwarded or not.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (i_reg_re) begin
            r_hold <= w_rd_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ip          <= IP_RESET;
            r_ip_redirect <= 1'b0;
        end else begin
            if (i_ip_set) begin
                r_ip <= i_ip_val;
            end else if (i_ip_inc) begin
                r_ip <= r_ip + XLEN'(i_ip_step);
            end
            r_ip_redirect <= i_ip_set;
        end
    end

    assign o_ip          = r_ip;
    assign o_ip_redirect = r_ip_redirect;

endmodule
